// File: rtl/pipe_regfile.sv
// rtl/pipe_regfile.sv - N-read/1-write register file with write bypass and pending-write scoreboard
module pipe_regfile #(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2,
    parameter int CNTW  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    output logic [NRD*WIDTH-1:0] rd_data_o,
    output logic [NRD-1:0]       rd_busy_o,
    input  logic                 we_i,
    input  logic [AW-1:0]        wa_i,
    input  logic [WIDTH-1:0]     wd_i,
    input  logic                 wb_retire_i,
    input  logic                 iss_valid_i,
    input  logic [AW-1:0]        iss_addr_i,
    output logic                 iss_ready_o,
    input  logic                 flush_i
);

    localparam int              NREGS   = 1 << AW;
    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic [CNTW-1:0]  cnt_q [NREGS];
    logic [CNTW-1:0]  cnt_d [NREGS];
    logic             iss_accept;
    logic             wb_ret;

    // iss_ready depends only on iss_addr and counter state, never on read addresses
    assign iss_ready_o = (iss_addr_i == '0) || (cnt_q[iss_addr_i] != CNT_MAX);
    assign iss_accept  = iss_valid_i && (iss_addr_i != '0) && iss_ready_o;
    assign wb_ret      = we_i && wb_retire_i && (wa_i != '0);

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush_i) begin
                cnt_d[r] = '0;
            end else if (iss_accept && (iss_addr_i == AW'(r)) &&
                         !(wb_ret && (wa_i == AW'(r)))) begin
                cnt_d[r] = cnt_q[r] + CNT_ONE;
            end else if (wb_ret && (wa_i == AW'(r)) && (cnt_q[r] != '0) &&
                         !(iss_accept && (iss_addr_i == AW'(r)))) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
                cnt_q[r] <= '0;
            end
        end else begin
            if (we_i && (wa_i != '0)) begin
                mem_q[wa_i] <= wd_i;
            end
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit_wr;

        assign addr   = rd_addr_i[i*AW +: AW];
        assign hit_wr = we_i && (wa_i == addr);

        assign rd_data_o[i*WIDTH +: WIDTH] = (addr == '0) ? '0 :
                                             hit_wr       ? wd_i : mem_q[addr];
        // last pending write retiring now is already visible through the bypass
        assign rd_busy_o[i] = (addr != '0) && (cnt_q[addr] != '0) &&
                              !((cnt_q[addr] == CNT_ONE) && wb_ret && (wa_i == addr));
    end

endmodule

// File: tb/tb_pipe_regfile.sv
// tb/tb_pipe_regfile.sv - directed and random checks of pipe_regfile against a reference model
module tb_pipe_regfile;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int NRD   = 4;
    localparam int CNTW  = 2;
    localparam int NREGS = 32;
    localparam int CMAX  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*WIDTH-1:0] rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 we;
    logic [AW-1:0]        wa;
    logic [WIDTH-1:0]     wd;
    logic                 wb_retire;
    logic                 iss_valid;
    logic [AW-1:0]        iss_addr;
    logic                 iss_ready;
    logic                 flush;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] ref_mem [NREGS];
    int               ref_cnt [NREGS];

    always #5 clk = ~clk;

    pipe_regfile #(.WIDTH(WIDTH), .AW(AW), .NRD(NRD), .CNTW(CNTW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_busy_o   (rd_busy),
        .we_i        (we),
        .wa_i        (wa),
        .wd_i        (wd),
        .wb_retire_i (wb_retire),
        .iss_valid_i (iss_valid),
        .iss_addr_i  (iss_addr),
        .iss_ready_o (iss_ready),
        .flush_i     (flush)
    );

    function automatic logic [WIDTH-1:0] exp_data(int a);
        if (a == 0) return '0;
        if (we && (int'(wa) == a)) return wd;
        return ref_mem[a];
    endfunction

    function automatic logic exp_busy(int a);
        if (a == 0 || ref_cnt[a] == 0) return 1'b0;
        if (ref_cnt[a] == 1 && we && wb_retire && int'(wa) == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_ready();
        return (iss_addr == '0) || (ref_cnt[iss_addr] < CMAX);
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NRD; i++) begin
            check($sformatf("rd_data%0d", i), rd_data[i*WIDTH +: WIDTH], exp_data(int'(rd_addr[i*AW +: AW])));
            check($sformatf("rd_busy%0d", i), WIDTH'(rd_busy[i]), WIDTH'(exp_busy(int'(rd_addr[i*AW +: AW]))));
        end
        check("iss_ready", WIDTH'(iss_ready), WIDTH'(exp_ready()));
    endtask

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) begin
            ref_mem[r] = '0;
            ref_cnt[r] = 0;
        end
    endtask

    task automatic model_edge();
        bit inc;
        bit ret;
        inc = iss_valid && iss_addr != 0 && ref_cnt[iss_addr] < CMAX;
        ret = we && wb_retire && wa != 0;
        if (we && wa != 0) ref_mem[wa] = wd;
        if (flush) begin
            for (int r = 0; r < NREGS; r++) ref_cnt[r] = 0;
        end else if (!(inc && ret && iss_addr == wa)) begin
            if (inc) ref_cnt[iss_addr] = ref_cnt[iss_addr] + 1;
            if (ret && ref_cnt[wa] > 0) ref_cnt[wa] = ref_cnt[wa] - 1;
        end
    endtask

    // inputs are set at the falling edge; check mid-cycle, update the model at the rising edge
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input int a, input logic [WIDTH-1:0] d, input logic ret,
                         input logic iv, input int ia, input logic fl);
        we = w; wa = AW'(a); wd = d; wb_retire = ret;
        iss_valid = iv; iss_addr = AW'(ia); flush = fl;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
        rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    initial begin
        rst_n = 1'b0;
        set_rd(5, 0, 3, 7);
        drive(0, 0, 0, 0, 0, 0, 0);
        model_clear();
        @(negedge clk);
        #1;
        check("reset_data0", rd_data[31:0], 32'h0);
        check("reset_busy", WIDTH'(rd_busy), 32'h0);
        check("reset_ready", WIDTH'(iss_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // write r5 with bypass in the write cycle, then r0 is ignored
        set_rd(5, 0, 0, 0);
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        #1 check("bypass_r5", rd_data[31:0], 32'hDEADBEEF);
        step();
        drive(1, 0, 32'h12345678, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("read_r5", rd_data[31:0], 32'hDEADBEEF);
        check("read_r0", rd_data[63:32], 32'h0);
        step();

        // all ports on r7, then one port on an unrelated register
        set_rd(7, 7, 7, 7);
        drive(1, 7, 32'hA5A5A5A5, 0, 0, 0, 0);
        #1 check("bypass_all_r7", rd_data, {4{32'hA5A5A5A5}});
        step();
        set_rd(7, 7, 7, 5);
        drive(1, 7, 32'h5A5A5A5A, 0, 0, 0, 0);
        #1 check("unrelated_port3", rd_data[127:96], 32'hDEADBEEF);
        step();

        // saturate r3, then retire past zero
        set_rd(3, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 1, 3, 0);
            step();
        end
        #1 check("r3_sat_ready", WIDTH'(iss_ready), 32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1, 3, 32'h300 + k, 1, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 check("r3_drained", WIDTH'(rd_busy[0]), 32'h0);
        step();

        // r9: simultaneous issue and retire, then lone retire at cnt==1
        set_rd(9, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 9, 0);
        step();
        drive(1, 9, 32'h99, 1, 1, 9, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 check("r9_still_busy", WIDTH'(rd_busy[0]), 32'h1);
        step();
        drive(1, 9, 32'h77, 1, 0, 0, 0);
        #1;
        check("r9_retire_busy", WIDTH'(rd_busy[0]), 32'h0);
        check("r9_retire_data", rd_data[31:0], 32'h77);
        step();

        // flush overrides a same-cycle issue
        set_rd(1, 2, 4, 0);
        drive(0, 0, 0, 0, 1, 1, 0); step();
        drive(0, 0, 0, 0, 1, 2, 0); step();
        drive(0, 0, 0, 0, 1, 2, 0); step();
        drive(0, 0, 0, 0, 1, 4, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 check("flush_busy", WIDTH'(rd_busy), 32'h0);
        step();

        // asynchronous reset between edges with r6 pending and stored
        set_rd(6, 6, 0, 0);
        drive(0, 0, 0, 0, 1, 6, 0); step();
        drive(1, 6, 32'h66, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 check("r6_pending", WIDTH'(rd_busy[0]), 32'h1);
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        check("async_rst_data", rd_data[31:0], 32'h0);
        check("async_rst_busy", WIDTH'(rd_busy), 32'h0);
        check_all();
        drive(1, 6, 32'hABCD, 1, 1, 6, 0);
        #1;
        check("rst_bypass", rd_data[31:0], 32'hABCD);
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 6, 32'h1, 1, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0); step();

        // random traffic over a small address window to provoke collisions
        for (int n = 0; n < 400; n++) begin
            set_rd($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            drive($urandom_range(0, 1), $urandom_range(0, 7), $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom_range(0, 39) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
